// File: rtl/ball_game_ctrl.sv
// Game sequencer for the bouncing-ball datapath: physics tick, serve/launch, paddle hits, score and lives.
// Optional beep generator enabled by defining BALL_GAME_BEEP_EN.
module ball_game_ctrl #(
  parameter int TICK_DIV = 48000,
  parameter int LIVES    = 3,
  parameter int HOME     = 20,
  parameter int SERVE_TK = 50,
  parameter int SCORE_W  = 8
`ifdef BALL_GAME_BEEP_EN
  ,
  parameter int BEEP_TK  = 25
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic [16:0]        ball_pos,
  input  logic               ball_stop,
  input  logic [8:0]         handline,
  output logic               tick,
  output logic               ball_run,
  output logic [8:0]         ball_home,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over,
  output logic               beep,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SERVE_TK + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TK - 1);

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q;
  logic [SW-1:0]        serve_q, serve_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic [16:0]          prev_q, prev_d;
  logic                 btn_q;
  logic                 start_rise;
  logic                 hit;

  assign start_rise = btn_start & ~btn_q;
  // Ball falling across the paddle between two consecutive physics ticks.
  assign hit = (prev_q < {8'd0, handline}) && (ball_pos >= {8'd0, handline});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      serve_q    <= '0;
      score_q    <= '0;
      lives_q    <= 2'(LIVES);
      prev_q     <= '0;
      btn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      serve_q    <= serve_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      prev_q     <= prev_d;
      btn_q      <= btn_start;
    end
  end

  always_comb begin
    state_d = state_q;
    serve_d = serve_q;
    score_d = score_q;
    lives_d = lives_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = SERVE;
          serve_d = '0;
          score_d = '0;
          lives_d = 2'(LIVES);
        end
      end
      SERVE: begin
        if (tick) begin
          if (serve_q == SERVE_LAST) begin
            state_d = PLAY;
            prev_d  = 17'(HOME);
          end else begin
            serve_d = serve_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          prev_d = ball_pos;
          if (hit && (score_q != {SCORE_W{1'b1}})) score_d = score_q + 1'b1;
          if (ball_stop) state_d = MISS;
        end
      end
      MISS: begin
        lives_d = lives_q - 2'd1;
        serve_d = '0;
        state_d = (lives_q == 2'd1) ? OVER : SERVE;
      end
      OVER: begin
        if (start_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign ball_run  = (state_q == PLAY);
  assign game_over = (state_q == OVER);
  assign ball_home = 9'(HOME);
  assign score     = score_q;
  assign lives     = lives_q;
  assign dbg_state = state_q;

`ifdef BALL_GAME_BEEP_EN
  localparam int BW = $clog2(2 * BEEP_TK + 1);

  logic [BW-1:0] beep_q, beep_d;
  logic          hit_evt, miss_evt;

  assign hit_evt  = (state_q == PLAY) && tick && hit;
  assign miss_evt = (state_q == PLAY) && tick && ball_stop;

  // A new event reloads even when a tick would decrement on the same clock.
  always_comb begin
    beep_d = beep_q;
    if (miss_evt)                     beep_d = BW'(2 * BEEP_TK);
    else if (hit_evt)                 beep_d = BW'(BEEP_TK);
    else if (tick && (beep_q != '0))  beep_d = beep_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) beep_q <= '0;
    else     beep_q <= beep_d;
  end

  assign beep = (beep_q != '0);
`else
  assign beep = 1'b0;
`endif

endmodule
